// File: rtl/load_store_initiator.sv
// load_store_initiator: single-outstanding load/store master with lane alignment, extension and WAIT timeout
module load_store_initiator #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ls_load,
  input  logic                    ls_store,
  input  logic [1:0]              ls_size,
  input  logic                    ls_unsigned,
  input  logic [ADDRESS_BITS-1:0] ls_address,
  input  logic [DATA_WIDTH-1:0]   ls_store_data,
  output logic [DATA_WIDTH-1:0]   ls_load_data,
  output logic                    ls_done,
  output logic                    ls_misaligned,
  output logic                    ls_error,
  output logic                    ls_busy,
  output logic                    d_mem_read,
  output logic                    d_mem_write,
  output logic [3:0]              d_mem_byte_en,
  output logic [ADDRESS_BITS-1:0] d_mem_address,
  output logic [DATA_WIDTH-1:0]   d_mem_data_out,
  input  logic [DATA_WIDTH-1:0]   d_mem_data_in,
  input  logic [ADDRESS_BITS-1:0] d_mem_address_in,
  input  logic                    d_mem_valid,
  input  logic                    d_mem_ready
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d, store_q, store_d, err_q, err_d, mis_q, mis_d;
  logic [3:0]              be_q, be_d, be_new;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, wdata_new, rdata_q, rdata_d, lane, ext;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    one_req, illegal, misaligned, accept, timeout;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      store_q <= 1'b0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      store_q <= store_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    one_req    = ls_load ^ ls_store;
    illegal    = (ls_load & ls_store) | (one_req & ls_size == 2'd3);
    misaligned = one_req & ((ls_size == 2'd1 & ls_address[0]) | (ls_size == 2'd2 & ls_address[1:0] != 2'd0));
    be_new     = ls_size == 2'd0 ? 4'b0001 << ls_address[1:0] :
                 ls_size == 2'd1 ? (ls_address[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_new  = ls_size == 2'd0 ? {4{ls_store_data[7:0]}} :
                 ls_size == 2'd1 ? {2{ls_store_data[15:0]}} : ls_store_data;
    // halves are aligned, so the byte-offset shift also selects the correct half lane
    lane       = d_mem_data_in >> {addr_q[1:0], 3'b000};
    ext        = size_q == 2'd0 ? {{24{~uns_q & lane[7]}}, lane[7:0]} :
                 size_q == 2'd1 ? {{16{~uns_q & lane[15]}}, lane[15:0]} : lane;
    accept     = state_q == WAIT && d_mem_valid && ((d_mem_address_in ^ addr_q) >> 2) == '0;
    timeout    = state_q == WAIT && !accept && cnt_q == CW'(TIMEOUT_CYCLES);
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    store_d = store_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    mis_d   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = illegal;
        mis_d = !illegal && misaligned;
        if (one_req && !illegal && !misaligned) begin
          state_d = REQ;
          addr_d  = ls_address;
          size_d  = ls_size;
          uns_d   = ls_unsigned;
          store_d = ls_store;
          be_d    = be_new;
          wdata_d = wdata_new;
        end
      end
      REQ: begin
        cnt_d = '0;
        if (d_mem_ready) state_d = store_q ? DONE : WAIT;
      end
      WAIT: begin
        cnt_d   = cnt_q + 1'b1;
        rdata_d = accept ? ext : rdata_q;
        err_d   = timeout;
        state_d = accept ? DONE : timeout ? IDLE : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    ls_busy        = state_q != IDLE;
    ls_done        = state_q == DONE;
    ls_error       = err_q;
    ls_misaligned  = mis_q;
    d_mem_write    = state_q == REQ && store_q;
    d_mem_read     = (state_q == REQ && !store_q) || state_q == WAIT;
    d_mem_byte_en  = be_q;
    d_mem_address  = addr_q;
    d_mem_data_out = wdata_q;
    ls_load_data   = rdata_q;
  end
endmodule
